// File: rtl/oldland_dbus_pkg.sv
// Shared types and defaults for the Oldland data-bus controller.
package oldland_dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAM_RESP,
    ST_PERIPH_WAIT,
    ST_RESPOND
  } state_e;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_PERIPH,
    REG_UNMAPPED
  } region_e;

  localparam int          DEFAULT_RAM_ADDR_BITS = 12;
  localparam logic [31:0] DEFAULT_PERIPH_BASE   = 32'h8000_0000;
  localparam int          DEFAULT_TIMEOUT       = 255;

  // RAM occupies every byte address below 4 * 2^ram_addr_bits.
  function automatic region_e decode_region(input logic [31:0] addr,
                                            input int          ram_addr_bits,
                                            input logic [31:0] periph_base);
    if ((addr >> (ram_addr_bits + 2)) == 32'd0) return REG_RAM;
    if (addr[31:28] == periph_base[31:28]) return REG_PERIPH;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/oldland_dbus_decode.sv
// Combinational region classifier for a data-bus address.
module oldland_dbus_decode
  import oldland_dbus_pkg::*;
#(
  parameter int          RAM_ADDR_BITS = DEFAULT_RAM_ADDR_BITS,
  parameter logic [31:0] PERIPH_BASE   = DEFAULT_PERIPH_BASE
) (
  input  logic [31:0] d_addr,
  output region_e     region
);

  assign region = decode_region(d_addr, RAM_ADDR_BITS, PERIPH_BASE);

endmodule

// File: rtl/oldland_dbus_ctrl.sv
// Data-bus controller: routes memory-stage requests to on-chip RAM, the
// peripheral bus (with timeout) or a bus error, returning a one-cycle ack/error.
module oldland_dbus_ctrl
  import oldland_dbus_pkg::*;
#(
  parameter int          RAM_ADDR_BITS = DEFAULT_RAM_ADDR_BITS,
  parameter logic [31:0] PERIPH_BASE   = DEFAULT_PERIPH_BASE,
  parameter int          TIMEOUT       = DEFAULT_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              d_addr,
  input  logic [3:0]               d_bytesel,
  input  logic                     d_wr_en,
  input  logic [31:0]              d_wr_val,
  input  logic                     d_access,
  output logic [31:0]              d_data,
  output logic                     d_ack,
  output logic                     d_error,
  output logic                     ram_en,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [3:0]               ram_bytesel,
  output logic                     ram_wr_en,
  output logic [31:0]              ram_wr_data,
  input  logic [31:0]              ram_rd_data,
  output logic [31:0]              p_addr,
  output logic [3:0]               p_bytesel,
  output logic                     p_wr_en,
  output logic [31:0]              p_wr_val,
  output logic                     p_access,
  input  logic [31:0]              p_data,
  input  logic                     p_ack,
  input  logic                     p_error
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          err_q, err_d;
  logic          wr_q, wr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   p_addr_q, p_addr_d;
  logic [3:0]    p_bytesel_q, p_bytesel_d;
  logic          p_wr_en_q, p_wr_en_d;
  logic [31:0]   p_wr_val_q, p_wr_val_d;
  logic          p_access_q, p_access_d;
  region_e       region;

  oldland_dbus_decode #(
    .RAM_ADDR_BITS(RAM_ADDR_BITS),
    .PERIPH_BASE  (PERIPH_BASE)
  ) u_decode (
    .d_addr(d_addr),
    .region(region)
  );

  assign p_addr    = p_addr_q;
  assign p_bytesel = p_bytesel_q;
  assign p_wr_en   = p_wr_en_q;
  assign p_wr_val  = p_wr_val_q;
  assign p_access  = p_access_q;
  assign ram_addr  = d_addr[RAM_ADDR_BITS+1:2];

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    wr_d        = wr_q;
    rdata_d     = rdata_q;
    timer_d     = timer_q;
    p_addr_d    = p_addr_q;
    p_bytesel_d = p_bytesel_q;
    p_wr_en_d   = p_wr_en_q;
    p_wr_val_d  = p_wr_val_q;
    p_access_d  = p_access_q;
    ram_en      = 1'b0;
    ram_bytesel = 4'b0;
    ram_wr_en   = 1'b0;
    ram_wr_data = 32'b0;
    d_ack       = 1'b0;
    d_error     = 1'b0;
    d_data      = 32'b0;

    case (state_q)
      ST_IDLE: begin
        if (d_access) begin
          case (region)
            REG_RAM: begin
              ram_en      = 1'b1;
              ram_bytesel = d_bytesel;
              ram_wr_en   = d_wr_en;
              ram_wr_data = d_wr_val;
              wr_d        = d_wr_en;
              state_d     = ST_RAM_RESP;
            end
            REG_PERIPH: begin
              p_addr_d    = d_addr;
              p_bytesel_d = d_bytesel;
              p_wr_en_d   = d_wr_en;
              p_wr_val_d  = d_wr_val;
              p_access_d  = 1'b1;
              timer_d     = '0;
              state_d     = ST_PERIPH_WAIT;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_RESPOND;
            end
          endcase
        end
      end
      ST_RAM_RESP: begin
        d_ack   = 1'b1;
        d_data  = wr_q ? 32'b0 : ram_rd_data;
        state_d = ST_IDLE;
      end
      ST_PERIPH_WAIT: begin
        timer_d = timer_q + TW'(1);
        // Priority: peripheral error, then ack, then timeout.
        if (p_error) begin
          err_d      = 1'b1;
          p_access_d = 1'b0;
          state_d    = ST_RESPOND;
        end else if (p_ack) begin
          rdata_d    = p_wr_en_q ? 32'b0 : p_data;
          err_d      = 1'b0;
          p_access_d = 1'b0;
          state_d    = ST_RESPOND;
        end else if (timer_q == TIMER_LAST) begin
          err_d      = 1'b1;
          p_access_d = 1'b0;
          state_d    = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        d_ack   = !err_q;
        d_error = err_q;
        d_data  = err_q ? 32'b0 : rdata_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // RAM strobes are combinational, so hold them off while reset is asserted.
    if (!rst_n) begin
      ram_en      = 1'b0;
      ram_bytesel = 4'b0;
      ram_wr_en   = 1'b0;
      ram_wr_data = 32'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      err_q       <= 1'b0;
      wr_q        <= 1'b0;
      rdata_q     <= 32'b0;
      timer_q     <= '0;
      p_addr_q    <= 32'b0;
      p_bytesel_q <= 4'b0;
      p_wr_en_q   <= 1'b0;
      p_wr_val_q  <= 32'b0;
      p_access_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      wr_q        <= wr_d;
      rdata_q     <= rdata_d;
      timer_q     <= timer_d;
      p_addr_q    <= p_addr_d;
      p_bytesel_q <= p_bytesel_d;
      p_wr_en_q   <= p_wr_en_d;
      p_wr_val_q  <= p_wr_val_d;
      p_access_q  <= p_access_d;
    end
  end

endmodule
